timer_cfg_sequencer: RTL and testbench
======================================

// Module: timer_cfg_sequencer
// PURPOSE
//  APB master sequencer that configures and services the 8-bit timer's APB slave (TDR/TCR/TSR).
//  Turns one high-level command (load value, clock select, direction, start) into the ordered APB write burst.
//  Watches tmr_ovf/tmr_udf, then reads and clears TSR and raises a 1-cycle irq with the captured flags.
//  Sits between the system control logic and the timer's APB port; it is the timer's only APB master.
// PARAMETERS
//  TIMEOUT_CYC  16  max ACCESS cycles waiting for m_pready before abort (>=2)
// PORTS
//  PCLK         in   1  single clock, rising edge
//  PRESETn      in   1  asynchronous active-low reset
//  cmd_valid    in   1  command request
//  cmd_ready    out  1  command accepted on cycle cmd_valid&cmd_ready
//  cmd_tdr      in   8  reload value written to TDR
//  cmd_cks      in   2  clock select -> TCR[1:0]
//  cmd_down     in   1  1=count down -> TCR[5]
//  cmd_start    in   1  1=enable after load -> TCR[4]
//  m_psel       out  1  APB select
//  m_penable    out  1  APB enable
//  m_pwrite     out  1  APB direction
//  m_paddr      out  2  APB address: TDR=2'b00, TCR=2'b01, TSR=2'b10
//  m_pwdata     out  8  APB write data
//  m_prdata     in   8  APB read data
//  m_pready     in   1  APB ready
//  m_pslverr    in   1  APB slave error, sampled with m_pready
//  tmr_ovf      in   1  timer overflow flag (level)
//  tmr_udf      in   1  timer underflow flag (level)
//  irq          out  1  1-cycle pulse when a TSR service completes
//  irq_flags    out  2  {udf,ovf} = TSR[1:0] captured by the service read; held until next service
//  busy         out  1  sequence in progress (state != IDLE)
//  err          out  1  1-cycle pulse: pslverr or timeout; remaining ops dropped
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; svc_pend=0; op_idx=0; timeout cnt=0.
//  FSM: IDLE -> SETUP -> ACCESS -> (SETUP for next op | IDLE after last op or abort).
//   SETUP: psel=1, penable=0, paddr/pwrite/pwdata driven for op[op_idx]; 1 cycle.
//   ACCESS: psel=1, penable=1, signals held stable; done on cycle m_pready=1.
//   No psel-high idle gap between ops; after the last op psel=0 for >=1 cycle in IDLE.
//  CMD sequence (3 writes, values latched at accept):
//   W TDR=cmd_tdr; W TCR={1'b1,1'b0,down,1'b0,2'b00,cks} (load); W TCR={2'b00,down,start,2'b00,cks}.
//  SVC sequence: R TSR (capture m_prdata[1:0] on done); W TSR=8'h00 (clear); irq pulses the cycle after the clear completes.
//  svc_pend: set on rising edge of (tmr_ovf|tmr_udf), registered; cleared when SVC starts; edges during a sequence are kept pending.
//  Arbitration in IDLE: svc_pend wins over cmd_valid; cmd_ready=1 only in IDLE with svc_pend=0.
//  Timeout: counter runs in ACCESS; at TIMEOUT_CYC cycles without m_pready -> psel=0, err pulse, IDLE.
//  pslverr on a done cycle -> err pulse, remaining ops dropped, IDLE; SVC aborted -> no irq, flags unchanged.
//  Reset mid-transfer: outputs drop to 0 asynchronously; the partial command is discarded (no replay).
//  Command latency: accept at cycle 0 -> first SETUP at cycle 1; zero-wait burst ends after 6 cycles.
// STRUCTURE
//  Package timer_pkg: address localparams (TDR/TCR/TSR), TCR bit indices (LOAD=7, DOWN=5, EN=4, CKS=1:0),
//   TSR bits (OVF=0, UDF=1), FSM state encoding.
//  One natural sub-module: apb_master_if (SETUP/ACCESS handshake + timeout) driven by an op table.
// TESTING
//  cmd tdr=8'hF0,cks=2,down=0,start=1, pready tied 1 -> writes 00:F0, 01:82, 01:12 in 6 cycles; cmd_ready low 6 cycles.
//  pready delayed 3 cycles on 2nd write -> address/data stable across wait; total 9 cycles; no err.
//  tmr_ovf rises, prdata=8'h01 on TSR read -> R 10, W 10:00, irq 1 cycle, irq_flags=2'b01.
//  cmd_valid and ovf edge in the same IDLE cycle -> SVC runs first, cmd accepted after; both sequences complete.
//  pready held 0 for TIMEOUT_CYC cycles -> err pulse, psel=0, busy=0, next cmd accepted.
//  pslverr on 1st write; separately, PRESETn low mid-ACCESS -> err/abort or reset clears all; no further APB ops.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer configuration sequencer: timer register
// map, TCR/TSR bit positions, APB master state encoding and operation record.
package timer_pkg;

  // Timer register addresses on its APB slave port
  localparam logic [1:0] ADDR_TDR = 2'b00;
  localparam logic [1:0] ADDR_TCR = 2'b01;
  localparam logic [1:0] ADDR_TSR = 2'b10;

  // TCR bit positions
  localparam int TCR_LOAD   = 7;
  localparam int TCR_DOWN   = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  // TSR bit positions
  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  // Number of APB operations in each sequence
  localparam int CMD_OPS = 3;
  localparam int SVC_OPS = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  typedef enum logic {
    SEQ_CMD = 1'b0,
    SEQ_SVC = 1'b1
  } seq_t;

  // One APB operation as presented to the bus engine
  typedef struct packed {
    logic       write;
    logic [1:0] addr;
    logic [7:0] wdata;
  } apb_op_t;

  // Assemble a TCR write value from its fields
  function automatic logic [7:0] tcr_value(input logic load, input logic down,
                                           input logic en, input logic [1:0] cks);
    logic [7:0] v;
    v = 8'h00;
    v[TCR_LOAD] = load;
    v[TCR_DOWN] = down;
    v[TCR_EN]   = en;
    v[TCR_CKS_HI:TCR_CKS_LO] = cks;
    return v;
  endfunction

endpackage

// File: rtl/timer_apb_master_if.sv
// APB master bus engine: runs SETUP/ACCESS for the operation presented on
// op, chains straight into the next SETUP when more is set, and aborts on
// slave error or when the slave stalls ACCESS for TIMEOUT_CYC cycles.
//
// Handshake: start is honoured only in IDLE. A transfer completes on the
// ACCESS cycle with m_pready=1; done_ok flags a clean completion and abort
// flags pslverr on that cycle or an expired wait. op must stay stable from
// SETUP until completion.
module apb_master_if
  import timer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       start,
  input  logic       more,
  input  apb_op_t    op,
  output logic       m_psel,
  output logic       m_penable,
  output logic       m_pwrite,
  output logic [1:0] m_paddr,
  output logic [7:0] m_pwdata,
  input  logic       m_pready,
  input  logic       m_pslverr,
  output apb_state_t state,
  output logic       done_ok,
  output logic       abort
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  apb_state_t    state_q;
  apb_state_t    state_d;
  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  assign timed_out = (wait_cnt == CW'(TIMEOUT_CYC - 1));
  assign state     = state_q;

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Count ACCESS cycles spent waiting for the slave
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                                wait_cnt <= '0;
    else if (state_q == ST_ACCESS && !m_pready)  wait_cnt <= wait_cnt + CW'(1);
    else                                         wait_cnt <= '0;
  end

  // Next-state: single SETUP, ACCESS until ready, chain or return to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (abort)        state_d = ST_IDLE;
        else if (done_ok) state_d = more ? ST_SETUP : ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Bus outputs and completion decode
  always_comb begin
    m_psel    = 1'b0;
    m_penable = 1'b0;
    m_pwrite  = 1'b0;
    m_paddr   = 2'b00;
    m_pwdata  = 8'h00;
    done_ok   = 1'b0;
    abort     = 1'b0;
    if (state_q != ST_IDLE) begin
      m_psel   = 1'b1;
      m_pwrite = op.write;
      m_paddr  = op.addr;
      m_pwdata = op.write ? op.wdata : 8'h00;
    end
    if (state_q == ST_ACCESS) begin
      m_penable = 1'b1;
      if (m_pready) begin
        done_ok = !m_pslverr;
        abort   = m_pslverr;
      end else begin
        abort   = timed_out;
      end
    end
  end

endmodule

// File: rtl/timer_cfg_sequencer.sv
// Timer configuration sequencer: turns one configuration command into the
// TDR / TCR(load) / TCR(run) write burst, and services timer overflow or
// underflow events by reading then clearing TSR and pulsing irq.
//
// Handshake: a command is taken on the cycle cmd_valid & cmd_ready. cmd_ready
// is high only when idle with no service pending; a pending service (including
// an event edge in the same cycle) always wins over a command.
module timer_cfg_sequencer
  import timer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_tdr,
  input  logic [1:0] cmd_cks,
  input  logic       cmd_down,
  input  logic       cmd_start,
  output logic       m_psel,
  output logic       m_penable,
  output logic       m_pwrite,
  output logic [1:0] m_paddr,
  output logic [7:0] m_pwdata,
  input  logic [7:0] m_prdata,
  input  logic       m_pready,
  input  logic       m_pslverr,
  input  logic       tmr_ovf,
  input  logic       tmr_udf,
  output logic       irq,
  output logic [1:0] irq_flags,
  output logic       busy,
  output logic       err
);

  apb_state_t state;
  apb_op_t    op;
  seq_t       seq;
  logic [1:0] op_idx;
  logic [7:0] tdr_q;
  logic [1:0] cks_q;
  logic       down_q;
  logic       start_q;
  logic [1:0] cap_flags;
  logic       live;
  logic       evt_q;
  logic       evt_edge;
  logic       svc_pend;
  logic       pending;
  logic       idle;
  logic       start_svc;
  logic       start_cmd;
  logic       last_op;
  logic       done_ok;
  logic       abort;
  logic       unused_prdata;

  // Only the flag bits of TSR are of interest
  assign unused_prdata = ^m_prdata[7:2];

  assign evt_edge  = (tmr_ovf | tmr_udf) & ~evt_q;
  assign pending   = svc_pend | evt_edge;
  assign idle      = (state == ST_IDLE) & live;
  assign start_svc = idle & pending;
  assign cmd_ready = idle & ~pending;
  assign start_cmd = cmd_valid & cmd_ready;
  assign busy      = (state != ST_IDLE);
  assign last_op   = (seq == SEQ_CMD) ? (op_idx == 2'(CMD_OPS - 1))
                                      : (op_idx == 2'(SVC_OPS - 1));

  apb_master_if #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_apb (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .start     (start_svc | start_cmd),
    .more      (~last_op),
    .op        (op),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr),
    .state     (state),
    .done_ok   (done_ok),
    .abort     (abort)
  );

  // Operation table indexed by the active sequence and op_idx
  always_comb begin
    op = '0;
    if (seq == SEQ_CMD) begin
      op.write = 1'b1;
      case (op_idx)
        2'd0: begin
          op.addr  = ADDR_TDR;
          op.wdata = tdr_q;
        end
        2'd1: begin
          op.addr  = ADDR_TCR;
          op.wdata = tcr_value(1'b1, down_q, 1'b0, cks_q);
        end
        default: begin
          op.addr  = ADDR_TCR;
          op.wdata = tcr_value(1'b0, down_q, start_q, cks_q);
        end
      endcase
    end else begin
      op.addr  = ADDR_TSR;
      op.wdata = 8'h00;
      op.write = (op_idx != 2'd0);
    end
  end

  // Hold off commands for the first cycle after reset release; detect event edges
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      live     <= 1'b0;
      evt_q    <= 1'b0;
      svc_pend <= 1'b0;
    end else begin
      live  <= 1'b1;
      evt_q <= tmr_ovf | tmr_udf;
      if (start_svc)     svc_pend <= 1'b0;
      else if (evt_edge) svc_pend <= 1'b1;
    end
  end

  // Sequence selection, op index stepping and command field capture
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      seq     <= SEQ_CMD;
      op_idx  <= 2'd0;
      tdr_q   <= 8'h00;
      cks_q   <= 2'b00;
      down_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      if (start_svc || start_cmd) begin
        seq    <= start_svc ? SEQ_SVC : SEQ_CMD;
        op_idx <= 2'd0;
      end else if (abort) begin
        op_idx <= 2'd0;
      end else if (done_ok) begin
        op_idx <= last_op ? 2'd0 : op_idx + 2'd1;
      end
      if (start_cmd) begin
        tdr_q   <= cmd_tdr;
        cks_q   <= cmd_cks;
        down_q  <= cmd_down;
        start_q <= cmd_start;
      end
    end
  end

  // Status pulses and captured TSR flags; an aborted service leaves irq_flags alone
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err       <= 1'b0;
      irq       <= 1'b0;
      irq_flags <= 2'b00;
      cap_flags <= 2'b00;
    end else begin
      err <= abort;
      irq <= done_ok & (seq == SEQ_SVC) & last_op;
      if (done_ok && seq == SEQ_SVC && op_idx == 2'd0)
        cap_flags <= {m_prdata[TSR_UDF], m_prdata[TSR_OVF]};
      if (done_ok && seq == SEQ_SVC && last_op)
        irq_flags <= cap_flags;
    end
  end

endmodule

// File: tb/tb_timer_cfg_sequencer.sv
// Directed bench for timer_cfg_sequencer: an APB slave responder with
// per-transfer wait/error scripting, a bus/pulse monitor, and a linear list
// of steps checked against hand-computed transfers and cycle counts.
module tb_timer_cfg_sequencer;

  localparam int TO = 16;

  logic       pclk;
  logic       presetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_tdr;
  logic [1:0] cmd_cks;
  logic       cmd_down;
  logic       cmd_start;
  logic       m_psel;
  logic       m_penable;
  logic       m_pwrite;
  logic [1:0] m_paddr;
  logic [7:0] m_pwdata;
  logic [7:0] m_prdata;
  logic       m_pready;
  logic       m_pslverr;
  logic       tmr_ovf;
  logic       tmr_udf;
  logic       irq;
  logic [1:0] irq_flags;
  logic       busy;
  logic       err;

  // Scoreboard: {write, addr, data} per completed transfer
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  int          wait_q[$];
  bit          slverr_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state
  int         acc_cnt = 0;
  int         irq_cnt = 0, irq_wide = 0, err_cnt = 0, err_wide = 0;
  int         ready_bad = 0, unstable = 0, proto_bad = 0;
  bit         prev_wait = 0, prev_psel = 0, prev_irq = 0, prev_err = 0;
  logic [10:0] prev_bus = '0;

  timer_cfg_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .PCLK      (pclk),
    .PRESETn   (presetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_tdr   (cmd_tdr),
    .cmd_cks   (cmd_cks),
    .cmd_down  (cmd_down),
    .cmd_start (cmd_start),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr),
    .tmr_ovf   (tmr_ovf),
    .tmr_udf   (tmr_udf),
    .irq       (irq),
    .irq_flags (irq_flags),
    .busy      (busy),
    .err       (err)
  );

  // Clock
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Slave responder and bus monitor, evaluated mid-cycle
  always @(negedge pclk) begin
    logic [10:0] cur_bus;
    int          cur_wait;
    cur_bus = {m_pwrite, m_paddr, m_pwrite ? m_pwdata : m_prdata};
    if (!presetn) begin
      m_pready = 1'b0; m_pslverr = 1'b0; acc_cnt = 0;
      prev_wait = 0; prev_psel = 0; prev_irq = 0; prev_err = 0;
    end else begin
      if (prev_wait && m_psel && (!m_penable || cur_bus != prev_bus)) unstable++;
      if (m_penable && !prev_psel) proto_bad++;
      if (busy && cmd_ready) ready_bad++;
      if (irq) begin irq_cnt++; if (prev_irq) irq_wide++; end
      if (err) begin err_cnt++; if (prev_err) err_wide++; end
      if (m_psel && m_penable) begin
        cur_wait = (wait_q.size() > 0) ? wait_q[0] : 0;
        if (acc_cnt >= cur_wait) begin
          m_pready  = 1'b1;
          m_pslverr = (slverr_q.size() > 0) ? slverr_q[0] : 1'b0;
          obs_q.push_back(cur_bus);
          if (wait_q.size() > 0)   void'(wait_q.pop_front());
          if (slverr_q.size() > 0) void'(slverr_q.pop_front());
          acc_cnt = 0;
        end else begin
          m_pready = 1'b0; m_pslverr = 1'b0; acc_cnt++;
        end
      end else begin
        m_pready = 1'b0; m_pslverr = 1'b0; acc_cnt = 0;
      end
      prev_wait = m_psel && m_penable && !m_pready;
      prev_bus  = cur_bus;
      prev_psel = m_psel;
      prev_irq  = irq;
      prev_err  = err;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] xw(input logic [1:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic logic [10:0] xr(input logic [1:0] a, input logic [7:0] d);
    return {1'b0, a, d};
  endfunction

  task automatic check_xfers(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check($sformatf("%s_x%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_mon();
    #1;
    irq_cnt = 0; irq_wide = 0; err_cnt = 0; err_wide = 0; ready_bad = 0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic settle();
    repeat (2) @(negedge pclk);
    #1;
  endtask

  // Present a command (optionally raising tmr_ovf in the same cycle) and
  // return at the negedge of the first cycle after acceptance.
  task automatic send_cmd(input logic [7:0] tdr, input logic [1:0] cks, input logic down,
                          input logic start, input bit raise_ovf, output int waited);
    int n;
    n = 0;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_tdr = tdr; cmd_cks = cks; cmd_down = down; cmd_start = start;
    if (raise_ovf) tmr_ovf = 1'b1;
    #1;
    while (!cmd_ready && n < 200) begin
      @(negedge pclk);
      #1;
      n++;
    end
    check("cmd_accepted", (n < 200), 1'b1);
    waited = n;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 500) begin
      cyc++;
      @(negedge pclk);
    end
  endtask

  initial begin
    int cyc;
    int waited;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_tdr = 8'h00; cmd_cks = 2'b00;
    cmd_down = 1'b0; cmd_start = 1'b0; m_prdata = 8'h00; tmr_ovf = 1'b0; tmr_udf = 1'b0;
    m_pready = 1'b0; m_pslverr = 1'b0;

    // Reset state
    repeat (3) @(negedge pclk);
    #1;
    check("reset_outputs", {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, cmd_ready,
                            irq, irq_flags, busy, err}, 32'h0);
    @(negedge pclk);
    presetn = 1'b1;
    settle();
    check("ready_after_reset", cmd_ready, 1'b1);

    // Zero-wait command burst
    clear_mon();
    send_cmd(8'hF0, 2'd2, 1'b0, 1'b1, 1'b0, waited);
    wait_idle(cyc);
    check("burst_cycles", cyc, 6);
    settle();
    exp_q = '{xw(2'b00, 8'hF0), xw(2'b01, 8'h82), xw(2'b01, 8'h12)};
    check_xfers("burst");
    check("burst_ready_while_busy", ready_bad, 0);
    check("burst_err", err_cnt, 0);

    // Wait states on the second write
    clear_mon();
    wait_q = '{0, 3};
    send_cmd(8'h5A, 2'd1, 1'b1, 1'b0, 1'b0, waited);
    wait_idle(cyc);
    check("wait_cycles", cyc, 9);
    settle();
    exp_q = '{xw(2'b00, 8'h5A), xw(2'b01, 8'hA1), xw(2'b01, 8'h21)};
    check_xfers("wait");
    check("wait_stable", unstable, 0);
    check("wait_err", err_cnt, 0);

    // Overflow service
    clear_mon();
    m_prdata = 8'h01;
    @(negedge pclk);
    tmr_ovf = 1'b1;
    @(negedge pclk);
    wait_idle(cyc);
    check("ovf_svc_cycles", cyc, 4);
    settle();
    exp_q = '{xr(2'b10, 8'h01), xw(2'b10, 8'h00)};
    check_xfers("ovf_svc");
    check("ovf_irq_count", irq_cnt, 1);
    check("ovf_irq_width", irq_wide, 0);
    check("ovf_irq_flags", irq_flags, 2'b01);

    // Service aborted by slave error on the TSR read
    tmr_ovf = 1'b0;
    settle();
    clear_mon();
    m_prdata = 8'h02;
    slverr_q = '{1'b1};
    @(negedge pclk);
    tmr_udf = 1'b1;
    @(negedge pclk);
    wait_idle(cyc);
    check("svc_abort_cycles", cyc, 2);
    settle();
    exp_q = '{xr(2'b10, 8'h02)};
    check_xfers("svc_abort");
    check("svc_abort_err", err_cnt, 1);
    check("svc_abort_irq", irq_cnt, 0);
    check("svc_abort_flags_held", irq_flags, 2'b01);

    // Underflow service
    tmr_udf = 1'b0;
    settle();
    clear_mon();
    @(negedge pclk);
    tmr_udf = 1'b1;
    @(negedge pclk);
    wait_idle(cyc);
    settle();
    exp_q = '{xr(2'b10, 8'h02), xw(2'b10, 8'h00)};
    check_xfers("udf_svc");
    check("udf_irq_count", irq_cnt, 1);
    check("udf_irq_flags", irq_flags, 2'b10);

    // Command and overflow edge in the same idle cycle: service first
    tmr_udf = 1'b0;
    settle();
    clear_mon();
    m_prdata = 8'h01;
    send_cmd(8'h3C, 2'd3, 1'b1, 1'b1, 1'b1, waited);
    check("arb_cmd_wait", waited, 5);
    wait_idle(cyc);
    check("arb_cmd_cycles", cyc, 6);
    settle();
    exp_q = '{xr(2'b10, 8'h01), xw(2'b10, 8'h00), xw(2'b00, 8'h3C),
              xw(2'b01, 8'hA3), xw(2'b01, 8'h33)};
    check_xfers("arb");
    check("arb_irq_count", irq_cnt, 1);
    check("arb_irq_flags", irq_flags, 2'b01);

    // Timeout on the first write, then a clean command
    tmr_ovf = 1'b0;
    settle();
    clear_mon();
    wait_q = '{1000};
    send_cmd(8'h11, 2'd0, 1'b0, 1'b0, 1'b0, waited);
    wait_idle(cyc);
    check("timeout_cycles", cyc, 1 + TO);
    settle();
    wait_q.delete();
    check_xfers("timeout");
    check("timeout_err", err_cnt, 1);
    check("timeout_err_width", err_wide, 0);
    check("timeout_psel", m_psel, 1'b0);
    clear_mon();
    send_cmd(8'h77, 2'd2, 1'b0, 1'b1, 1'b0, waited);
    wait_idle(cyc);
    check("post_timeout_cycles", cyc, 6);
    settle();
    exp_q = '{xw(2'b00, 8'h77), xw(2'b01, 8'h82), xw(2'b01, 8'h12)};
    check_xfers("post_timeout");

    // Slave error on the first write drops the rest
    clear_mon();
    slverr_q = '{1'b1};
    send_cmd(8'h99, 2'd1, 1'b0, 1'b1, 1'b0, waited);
    wait_idle(cyc);
    check("slverr_cycles", cyc, 2);
    settle();
    exp_q = '{xw(2'b00, 8'h99)};
    check_xfers("slverr");
    check("slverr_err", err_cnt, 1);

    // Reset asserted mid-ACCESS
    clear_mon();
    wait_q = '{1000};
    send_cmd(8'hC3, 2'd0, 1'b1, 1'b1, 1'b0, waited);
    repeat (2) @(negedge pclk);
    #2;
    check("mid_access_psel", m_psel, 1'b1);
    presetn = 1'b0;
    #1;
    check("async_reset_outputs", {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, cmd_ready,
                                  irq, irq_flags, busy, err}, 32'h0);
    wait_q.delete();
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    repeat (8) @(negedge pclk);
    #1;
    check_xfers("no_replay");
    check("no_replay_busy", busy, 1'b0);
    clear_mon();
    send_cmd(8'hA5, 2'd1, 1'b0, 1'b1, 1'b0, waited);
    wait_idle(cyc);
    check("post_reset_cycles", cyc, 6);
    settle();
    exp_q = '{xw(2'b00, 8'hA5), xw(2'b01, 8'h81), xw(2'b01, 8'h11)};
    check_xfers("post_reset");

    check("total_unstable", unstable, 0);
    check("total_protocol", proto_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
